// File: rtl/socket_pkg.sv
// Shared constants and width helper for socket producers/consumers.
package socket_pkg;

  localparam int unsigned BUF_DEPTH = 3;

  // Bits needed to hold any value in 0..max_val (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned OCC_W = cnt_width(BUF_DEPTH);

endpackage

// File: rtl/socket_rd_buf.sv
// Small shift-register FIFO; head is always entry 0 so it comes straight from a flop.
module socket_rd_buf
  import socket_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OCC_W-1:0]      occ
);

  logic [DATA_WIDTH-1:0] mem   [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [OCC_W-1:0]      occ_d;
  logic                  push_ok;
  logic                  pop_ok;

  // A push against a full buffer is dropped even if a pop happens in the same cycle.
  assign push_ok = push & (occ < OCC_W'(BUF_DEPTH));
  assign pop_ok  = pop & (occ != '0);

  always_comb begin
    mem_d = mem;
    occ_d = occ;
    if (pop_ok) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++) begin
        mem_d[i] = mem[i + 1];
      end
      occ_d = occ - OCC_W'(1);
    end
    if (push_ok) begin
      mem_d[occ_d] = din;
      occ_d        = occ_d + OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      occ <= '0;
    end else begin
      mem <= mem_d;
      occ <= occ_d;
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/socket_reader.sv
// Drains a socket FIFO into a valid/ready stream with sof/eof framing and a frame counter.
module socket_reader
  import socket_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_sock_data,
  input  logic                  i_sock_dv,
  input  logic                  i_sock_empty,
  output logic                  o_sock_rd_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic [CNT_W-1:0]      o_frame_cnt,
  output logic                  o_err
);

  localparam int unsigned       BEAT_W    = cnt_width(FRAME_LEN - 1);
  localparam int unsigned       SUM_W     = OCC_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  logic              live_q;
  logic              inflight_q;
  logic              err_q;
  logic [BEAT_W-1:0] beat_q;
  logic [CNT_W-1:0]  frame_q;
  logic [OCC_W-1:0]  occ;
  logic              hs;

  socket_rd_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .push (i_sock_dv),
    .din  (i_sock_data),
    .pop  (hs),
    .head (o_data),
    .occ  (occ)
  );

  // Reads are credited against buffered plus in-flight words; live_q keeps rd_en low in reset.
  assign o_sock_rd_en = live_q & i_enable & ~i_sock_empty
                      & ((SUM_W'(occ) + SUM_W'(inflight_q)) < SUM_W'(BUF_DEPTH));

  assign o_valid     = (occ != '0);
  assign hs          = o_valid & i_ready;
  assign o_sof       = o_valid & (beat_q == '0);
  assign o_eof       = o_valid & (beat_q == LAST_BEAT);
  assign o_frame_cnt = frame_q;
  assign o_err       = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      live_q     <= 1'b0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      beat_q     <= '0;
      frame_q    <= '0;
    end else begin
      live_q     <= 1'b1;
      inflight_q <= o_sock_rd_en;
      if (i_sock_dv && !inflight_q) begin
        err_q <= 1'b1;
      end
      if (hs) begin
        if (o_eof) begin
          beat_q  <= '0;
          frame_q <= frame_q + CNT_W'(1);
        end else begin
          beat_q <= beat_q + BEAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_socket_reader.sv
// Directed bench for socket_reader: a socket model plus a word/frame scoreboard, checked every cycle.
module tb_socket_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable, ready;
  logic [7:0] sock_data;
  logic       sock_dv;
  logic       sock_empty;

  logic       rd_en, valid, sof, eof, err;
  logic [7:0] data;
  logic [15:0] frame_cnt;
  logic       rd_en2, valid2, sof2, eof2, err2;
  logic [7:0] data2;
  logic [1:0] frame_cnt2;

  logic [7:0] sock_mem [256];
  logic [7:0] wr_ptr, rd_ptr;
  logic       force_dv;

  logic [7:0] exp_q[$];
  int         beat_m, frame_m, frame2_m;
  logic       err_m, live_m, infl_m, dv_pend;
  int         cyc, first_hs, last_hs;
  int         n_checks, n_fail;
  logic [3:0] rdy_pat;

  always #5 clk = ~clk;

  assign sock_empty = (wr_ptr == rd_ptr);

  socket_reader #(.DATA_WIDTH(8), .FRAME_LEN(16), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_sock_data(sock_data), .i_sock_dv(sock_dv), .i_sock_empty(sock_empty),
    .o_sock_rd_en(rd_en), .o_data(data), .o_valid(valid), .i_ready(ready),
    .o_sof(sof), .o_eof(eof), .o_frame_cnt(frame_cnt), .o_err(err)
  );

  socket_reader #(.DATA_WIDTH(8), .FRAME_LEN(1), .CNT_W(2)) dut_f1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_sock_data(sock_data), .i_sock_dv(sock_dv), .i_sock_empty(sock_empty),
    .o_sock_rd_en(rd_en2), .o_data(data2), .o_valid(valid2), .i_ready(ready),
    .o_sof(sof2), .o_eof(eof2), .o_frame_cnt(frame_cnt2), .o_err(err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      sock_mem[wr_ptr] = 8'(first + i);
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    beat_m = 0; frame_m = 0; frame2_m = 0;
    err_m = 1'b0; live_m = 1'b0; infl_m = 1'b0; dv_pend = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_sof"}, 32'(sof), 32'd0);
    check({tag, "_eof"}, 32'(eof), 32'd0);
    check({tag, "_frame"}, 32'(frame_cnt), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_valid2"}, 32'(valid2), 32'd0);
    check({tag, "_frame2"}, 32'(frame_cnt2), 32'd0);
  endtask

  // One clock cycle: compare against the model, cross the edge, then advance model and socket.
  task automatic tick();
    int   occ_m;
    logic exp_rd, hs_m, exp_v;
    #1;
    occ_m  = exp_q.size() - (dv_pend ? 1 : 0);
    exp_v  = (occ_m != 0);
    exp_rd = live_m && enable && !sock_empty && ((occ_m + (infl_m ? 1 : 0)) < 3);
    check("rd_en", 32'(rd_en), 32'(exp_rd));
    check("valid", 32'(valid), 32'(exp_v));
    check("frame_cnt", 32'(frame_cnt), 32'(frame_m));
    check("err", 32'(err), 32'(err_m));
    check("rd_en_f1", 32'(rd_en2), 32'(exp_rd));
    check("frame_cnt_f1", 32'(frame_cnt2), 32'(frame2_m % 4));
    check("err_f1", 32'(err2), 32'(err_m));
    check("sof_f1", 32'(sof2), 32'(exp_v));
    check("eof_f1", 32'(eof2), 32'(exp_v));
    if (exp_v) begin
      check("data", 32'(data), 32'(exp_q[0]));
      check("data_f1", 32'(data2), 32'(exp_q[0]));
      check("sof", 32'(sof), 32'(beat_m == 0));
      check("eof", 32'(eof), 32'(beat_m == 15));
    end else begin
      check("sof_idle", 32'(sof), 32'd0);
      check("eof_idle", 32'(eof), 32'd0);
    end
    hs_m = exp_v && ready;
    if (hs_m) begin
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (dv_pend) begin
      if (!infl_m) err_m = 1'b1;
      if (occ_m >= 3) void'(exp_q.pop_back());
    end
    if (hs_m) begin
      void'(exp_q.pop_front());
      frame2_m++;
      if (beat_m == 15) begin
        beat_m = 0;
        frame_m++;
      end else begin
        beat_m++;
      end
    end
    infl_m  = exp_rd;
    live_m  = 1'b1;
    dv_pend = exp_rd || force_dv;
    if (exp_rd) begin
      sock_data = sock_mem[rd_ptr];
      exp_q.push_back(sock_mem[rd_ptr]);
      rd_ptr = rd_ptr + 8'd1;
    end else if (force_dv) begin
      sock_data = 8'hAA;
      exp_q.push_back(8'hAA);
    end
    sock_dv = dv_pend;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; first_hs = -1; last_hs = -1;
    enable = 1'b1; ready = 1'b1; force_dv = 1'b0;
    sock_dv = 1'b0; sock_data = 8'h00; wr_ptr = 8'd0; rd_ptr = 8'd0;
    rdy_pat = 4'b1001;
    model_reset();
    push_words(8'h01, 16);

    // Reset state, with socket non-empty and enable high.
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: one full frame at full rate.
    for (int i = 0; i < 60 && !(frame_m == 1 && exp_q.size() == 0); i++) tick();
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_contiguous", 32'(last_hs - first_hs), 32'd15);

    // 2: ready pattern 1,0,0,1.
    push_words(8'h11, 16);
    for (int i = 0; i < 120 && !(frame_m == 2 && exp_q.size() == 0); i++) begin
      ready = rdy_pat[i % 4];
      tick();
    end
    ready = 1'b1;
    check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

    // 3: socket runs dry mid-frame, refilled after a gap.
    push_words(8'h21, 5);
    for (int i = 0; i < 30 && !(beat_m == 5 && exp_q.size() == 0); i++) tick();
    for (int i = 0; i < 20; i++) tick();
    check("t3_gap_valid", 32'(valid), 32'd0);
    push_words(8'h26, 11);
    for (int i = 0; i < 40 && !(frame_m == 3 && exp_q.size() == 0); i++) tick();
    check("t3_frame_cnt", 32'(frame_cnt), 32'd3);

    // 4: enable dropped for 10 cycles with a full socket.
    push_words(8'h31, 16);
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_rd_off", 32'(rd_en), 32'd0);
    end
    check("t4_drained", 32'(valid), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 40 && !(frame_m == 4 && exp_q.size() == 0); i++) tick();
    check("t4_frame_cnt", 32'(frame_cnt), 32'd4);

    // 6: spurious data-valid sets the sticky error; captured word becomes beat 0.
    enable = 1'b0; ready = 1'b0;
    tick();
    check("t6_err_before", 32'(err), 32'd0);
    force_dv = 1'b1;
    tick();
    force_dv = 1'b0;
    tick();
    check("t6_err_set", 32'(err), 32'd1);
    check("t6_sof", 32'(sof), 32'd1);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t6_err_sticky", 32'(err), 32'd1);

    // 5: async reset with three words buffered mid-frame.
    push_words(8'h41, 8);
    enable = 1'b1; ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t5_full", 32'(valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t5_async");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 30 && !(rd_ptr == wr_ptr && exp_q.size() == 0); i++) tick();
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t5_beat_count", 32'(beat_m), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
